bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD up/down counter, successor to the single-digit decade counter used in the simulation examples. It counts in packed BCD across `DIGITS` decades with enable, direction, synchronous clear and parallel load. It provides a terminal-count output and a registered wrap pulse for cascading. Typical use is as a display or timer counter driving seven-segment decoders.

## Interface
- `DIGITS`, default 2: number of BCD decades; legal range 1..8.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `clear`  in  1  synchronous clear to zero.
- `en`  in  1  count enable.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `load`  in  1  synchronous parallel load request.
- `load_val`  in  4*DIGITS  packed BCD load value; digit 0 in bits [3:0].
- `cnt`  out  4*DIGITS  current count, packed BCD.
- `tc`  out  1  terminal count, combinational: all digits 9 when `up`=1, all digits 0 when `up`=0.
- `carry`  out  1  registered one-cycle wrap or borrow pulse.
- `load_err`  out  1  registered one-cycle pulse when a load is rejected.

## Operation
- Reset values: `cnt`=0, `carry`=0, `load_err`=0. `tc` follows `cnt` and `up`, so it is 0 out of reset when `up`=1 and 1 when `up`=0.
- Per-edge priority is `clear` > `load` > `en`. Only the highest-priority active request acts.
- `clear`: `cnt` becomes 0.
- `load`: every nibble of `load_val` must be ≤9.
  - Valid value: `cnt` takes `load_val`.
  - Any nibble in 10..15: `cnt` is unchanged and `load_err` pulses.
  - `en` is ignored on a load cycle either way.
- `en` with `up`=1:
  - Digit 0 increments.
  - Digit k increments only when digits 0..k-1 are all 9; each digit rolls 9→0.
  - All 9s → all 0s with `carry` pulsed.
- `en` with `up`=0:
  - Digit 0 decrements.
  - Digit k decrements only when digits 0..k-1 are all 0; each digit rolls 0→9.
  - All 0s → all 9s with `carry` pulsed (borrow).
- `en`=0 with no clear or load: `cnt` holds.
- Direction may change on any cycle and takes effect on the same edge.
- `cnt` never holds a non-BCD nibble.

## Timing
- `cnt` updates on the rising edge that samples the request, so latency is 1 cycle.
- `carry` and `load_err` are registered. Each is high for exactly the one cycle following the wrap or rejected-load edge, aligned with the new `cnt`.
- `tc` has zero latency relative to `cnt` and `up`, for combinational cascade gating.
- Consecutive wraps produce separate pulses. With `DIGITS`=1, `en` held high and `up`=1, `carry` is high once every 10 cycles.
- Asserting `reset` mid-count forces all outputs to reset values immediately, independent of `clock`. The first count happens on the first edge after deassertion.

## Configuration
- `BCD_COUNTER_SATURATE_EN` defined: counting saturates.
  - Up-count holds at all 9s; down-count holds at all 0s.
  - `carry` is never asserted.
  - `tc` remains high while held.
- Macro undefined: counting wraps and pulses `carry` as described in Operation.
- Clear, load, `load_err` and `tc` behaviour is identical in both builds.

## Test plan
All scenarios use `DIGITS`=2.
- Reset, then `en`=1 and `up`=1 for 99 cycles → `cnt`=8'h99, `tc`=1. Next edge → `cnt`=8'h00, `carry`=1 for one cycle; in saturate build `cnt` stays 8'h99 and `carry`=0.
- From `cnt`=0, `en`=1 and `up`=0 for 1 cycle → `cnt`=8'h99, `carry`=1. After 10 more cycles → `cnt`=8'h89.
- From `cnt`=8'h23, `load`=1 with `load_val`=8'h4A → `cnt` stays 8'h23 and `load_err`=1 for one cycle. Then `load_val`=8'h57 → `cnt`=8'h57 and `load_err`=0.
- `clear`, `load` and `en` all high with `load_val`=8'h57 → `cnt`=8'h00. Same cycle with `clear`=0 → `cnt`=8'h57, no increment.
- Count to 8'h09 and toggle `up` to 0 on the next edge → `cnt`=8'h08. Then `up`=1 twice → `cnt`=8'h10.
- Assert `reset` between clock edges while `cnt`=8'h42 → `cnt`=0 immediately. Count resumes on the first edge after release.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with clear, checked parallel load,
// terminal count and registered wrap pulse. Define BCD_COUNTER_SATURATE_EN to saturate instead of wrapping.
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  tc,
    output logic                  carry,
    output logic                  load_err
);

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    function automatic logic bcd_valid(input logic [4*DIGITS-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [4*DIGITS-1:0] step_cnt;
    logic                all9;
    logic                all0;
    logic                ripple;
    logic                load_ok;

    // A digit steps only while every lower digit sits at its rollover value.
    always_comb begin
        step_cnt = cnt;
        all9     = 1'b1;
        all0     = 1'b1;
        ripple   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (ripple) begin
                step_cnt[4*k +: 4] = up ? digit_inc(cnt[4*k +: 4]) : digit_dec(cnt[4*k +: 4]);
            end
            ripple = ripple & (up ? (cnt[4*k +: 4] == 4'd9) : (cnt[4*k +: 4] == 4'd0));
            all9   = all9 & (cnt[4*k +: 4] == 4'd9);
            all0   = all0 & (cnt[4*k +: 4] == 4'd0);
        end
    end

    assign tc      = up ? all9 : all0;
    assign load_ok = bcd_valid(load_val);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (load) begin
                if (load_ok) cnt <= load_val;
                else         load_err <= 1'b1;
            end else if (en) begin
`ifdef BCD_COUNTER_SATURATE_EN
                if (!tc) cnt <= step_cnt;
`else
                cnt   <= step_cnt;
                carry <= tc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter (DIGITS=2): vector table plus multi-cycle sequences.
module tb_bcd_updown_counter;

`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset, clear, en, up, load;
    logic [7:0] load_val;
    logic [7:0] cnt;
    logic       tc, carry, load_err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_updown_counter #(.DIGITS(2)) dut (
        .clock(clock), .reset(reset), .clear(clear), .en(en), .up(up),
        .load(load), .load_val(load_val), .cnt(cnt), .tc(tc),
        .carry(carry), .load_err(load_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       clr, ld, e, u;
        logic [7:0] lv;
        logic [7:0] ecnt;
        logic       etc, ecarry, eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic c, input logic l, input logic e,
                       input logic u, input logic [7:0] lv, input logic [7:0] ec,
                       input logic et, input logic ecy, input logic eer);
        vec_t v;
        v.name = nm; v.clr = c; v.ld = l; v.e = e; v.u = u; v.lv = lv;
        v.ecnt = ec; v.etc = et; v.ecarry = ecy; v.eerr = eer;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic u,
                         input logic [7:0] lv);
        @(negedge clock);
        clear = c; load = l; en = e; up = u; load_val = lv;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        #12;
        chk("reset_cnt", cnt, 8'h00);
        chk("reset_carry", {7'd0, carry}, 8'd0);
        chk("reset_err", {7'd0, load_err}, 8'd0);
        chk("reset_tc_up", {7'd0, tc}, 8'd0);
        up = 1'b0; #1;
        chk("reset_tc_down", {7'd0, tc}, 8'd1);
        up = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        //   name            clr ld en up  lv     cnt                 tc   carry        err
        add("inc1",          0, 0, 1, 1, 8'h00, 8'h01,              0, 0,           0);
        add("load23",        0, 1, 0, 1, 8'h23, 8'h23,              0, 0,           0);
        add("load4A_rej",    0, 1, 0, 1, 8'h4A, 8'h23,              0, 0,           1);
        add("load57",        0, 1, 0, 1, 8'h57, 8'h57,              0, 0,           0);
        add("clr_prio",      1, 1, 1, 1, 8'h57, 8'h00,              0, 0,           0);
        add("load_over_en",  0, 1, 1, 1, 8'h57, 8'h57,              0, 0,           0);
        add("load09",        0, 1, 0, 1, 8'h09, 8'h09,              0, 0,           0);
        add("dir_down",      0, 0, 1, 0, 8'h00, 8'h08,              0, 0,           0);
        add("dir_up1",       0, 0, 1, 1, 8'h00, 8'h09,              0, 0,           0);
        add("dir_up2",       0, 0, 1, 1, 8'h00, 8'h10,              0, 0,           0);
        add("hold",          0, 0, 0, 1, 8'h00, 8'h10,              0, 0,           0);
        add("load99",        0, 1, 0, 1, 8'h99, 8'h99,              1, 0,           0);
        add("wrap_up",       0, 0, 1, 1, 8'h00, SAT ? 8'h99 : 8'h00, SAT, !SAT,     0);
        add("load00_down",   0, 1, 0, 0, 8'h00, 8'h00,              1, 0,           0);
        add("wrap_down",     0, 0, 1, 0, 8'h00, SAT ? 8'h00 : 8'h99, SAT, !SAT,     0);
        add("load90",        0, 1, 0, 0, 8'h90, 8'h90,              0, 0,           0);
        add("borrow_dig1",   0, 0, 1, 0, 8'h00, 8'h89,              0, 0,           0);
        add("load0F_rej",    0, 1, 1, 0, 8'h0F, 8'h89,              0, 0,           1);
        add("loadF0_rej",    0, 1, 0, 1, 8'hF0, 8'h89,              0, 0,           1);
        add("clear",         1, 0, 0, 1, 8'h00, 8'h00,              0, 0,           0);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].ld, vecs[i].e, vecs[i].u, vecs[i].lv);
            tick();
            chk({vecs[i].name, "_cnt"}, cnt, vecs[i].ecnt);
            chk({vecs[i].name, "_tc"}, {7'd0, tc}, {7'd0, vecs[i].etc});
            chk({vecs[i].name, "_carry"}, {7'd0, carry}, {7'd0, vecs[i].ecarry});
            chk({vecs[i].name, "_err"}, {7'd0, load_err}, {7'd0, vecs[i].eerr});
        end

        // Full up-count from reset: 99 edges to 99, then wrap and a single carry pulse.
        drive(0, 0, 0, 1, 8'h00);
        reset = 1'b1; #1; reset = 1'b0;
        drive(0, 0, 1, 1, 8'h00);
        repeat (99) tick();
        chk("seqA_cnt99", cnt, 8'h99);
        chk("seqA_tc", {7'd0, tc}, 8'd1);
        chk("seqA_nocarry", {7'd0, carry}, 8'd0);
        tick();
        chk("seqA_wrap_cnt", cnt, SAT ? 8'h99 : 8'h00);
        chk("seqA_wrap_carry", {7'd0, carry}, {7'd0, !SAT});
        tick();
        chk("seqA_after_cnt", cnt, SAT ? 8'h99 : 8'h01);
        chk("seqA_after_carry", {7'd0, carry}, 8'd0);

        // Down-count from zero: borrow pulse, then ten more edges reach 89.
        drive(1, 0, 0, 0, 8'h00);
        tick();
        drive(0, 0, 1, 0, 8'h00);
        tick();
        chk("seqB_borrow_cnt", cnt, SAT ? 8'h00 : 8'h99);
        chk("seqB_borrow_carry", {7'd0, carry}, {7'd0, !SAT});
        repeat (10) tick();
        chk("seqB_cnt89", cnt, SAT ? 8'h00 : 8'h89);
        chk("seqB_carry_low", {7'd0, carry}, 8'd0);

        // Asynchronous reset between edges, then resume on the first edge after release.
        drive(0, 1, 0, 1, 8'h42);
        tick();
        chk("seqC_load42", cnt, 8'h42);
        drive(0, 0, 1, 1, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk("seqC_async_cnt", cnt, 8'h00);
        chk("seqC_async_tc", {7'd0, tc}, 8'd0);
        @(negedge clock);
        chk("seqC_held_cnt", cnt, 8'h00);
        reset = 1'b0;
        tick();
        chk("seqC_resume", cnt, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
